// File: rtl/tm_step_sequencer.sv
// Next/Done handshake sequencer for TuringMachine: loads state table and tape, then steps it.
// Optional STEP_LIMIT_EN adds max_steps_i; reaching it halts the run phase (0 = unlimited).
module tm_step_sequencer #(
    parameter int DW      = 6,
    parameter int PULSE_W = 2,
    parameter int PERIOD  = 16,
    parameter int CW      = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [DW-1:0] cmd_data_i,
    input  logic          cmd_last_i,
    input  logic          run_i,
    input  logic          step_i,
    input  logic          compute_done_i,
`ifdef STEP_LIMIT_EN
    input  logic [CW-1:0] max_steps_i,
`endif
    output logic [DW-1:0] tm_data_o,
    output logic          tm_next_o,
    output logic          tm_done_o,
    output logic          busy_o,
    output logic          halted_o,
    output logic [CW-1:0] step_count_o
);

    localparam int PW_W  = $clog2(PULSE_W) + 1;
    localparam int PER_W = $clog2(PERIOD) + 1;
    localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PULSE_W - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);

    typedef enum logic [3:0] {
        LOAD_IDLE = 4'd0,
        LOAD_HI   = 4'd1,
        LOAD_LO   = 4'd2,
        DONE_HI   = 4'd3,
        DONE_LO   = 4'd4,
        RUN_IDLE  = 4'd5,
        RUN_HI    = 4'd6,
        RUN_LO    = 4'd7,
        HALTED    = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [PW_W-1:0]  cnt_q, cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [1:0]       phase_q, phase_d;
    logic             last_q, last_d;
    logic             pend_q, pend_d;
    logic [CW-1:0]    sc_q, sc_d;
    logic [DW-1:0]    data_q, data_d;
    logic             next_q, next_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             limit_s;
    logic             pulse_end_s;

`ifdef STEP_LIMIT_EN
    assign limit_s = (max_steps_i != {CW{1'b0}}) && (sc_q == max_steps_i);
`else
    assign limit_s = 1'b0;
`endif

    assign pulse_end_s = (cnt_q == PW_LAST);

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        last_d  = last_q;
        pend_d  = pend_q;
        sc_d    = sc_q;
        data_d  = data_q;

        // Period counter is held expired while run is low so a rising run steps at once
        if (!run_i) begin
            per_d = PER_LAST;
        end else if (per_q != PER_LAST) begin
            per_d = per_q + PER_W'(1);
        end else begin
            per_d = per_q;
        end

        case (state_q)
            LOAD_IDLE: begin
                if (cmd_valid_i) begin
                    data_d  = cmd_data_i;
                    last_d  = cmd_last_i;
                    cnt_d   = {PW_W{1'b0}};
                    state_d = LOAD_HI;
                end else begin
                    state_d = LOAD_IDLE;
                end
            end
            LOAD_HI, DONE_HI, RUN_HI: begin
                if ((state_q == RUN_HI) && compute_done_i) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (pulse_end_s) begin
                    cnt_d = {PW_W{1'b0}};
                    case (state_q)
                        LOAD_HI: state_d = LOAD_LO;
                        DONE_HI: state_d = DONE_LO;
                        default: state_d = RUN_LO;
                    endcase
                end else begin
                    cnt_d = cnt_q + PW_W'(1);
                end
            end
            LOAD_LO: begin
                if (pulse_end_s) begin
                    cnt_d   = {PW_W{1'b0}};
                    state_d = last_q ? DONE_HI : LOAD_IDLE;
                end else begin
                    cnt_d = cnt_q + PW_W'(1);
                end
            end
            DONE_LO: begin
                if (pulse_end_s) begin
                    cnt_d   = {PW_W{1'b0}};
                    phase_d = phase_q + 2'd1;
                    state_d = (phase_q == 2'd0) ? LOAD_IDLE : RUN_IDLE;
                end else begin
                    cnt_d = cnt_q + PW_W'(1);
                end
            end
            RUN_LO: begin
                if (pulse_end_s) begin
                    cnt_d   = {PW_W{1'b0}};
                    pend_d  = 1'b0;
                    state_d = (pend_q || compute_done_i) ? HALTED : RUN_IDLE;
                end else begin
                    cnt_d  = cnt_q + PW_W'(1);
                    pend_d = pend_q | compute_done_i;
                end
            end
            RUN_IDLE: begin
                if (compute_done_i || limit_s) begin
                    state_d = HALTED;
                end else if (run_i ? (per_q == PER_LAST) : step_i) begin
                    state_d = RUN_HI;
                    cnt_d   = {PW_W{1'b0}};
                    pend_d  = 1'b0;
                    per_d   = run_i ? {PER_W{1'b0}} : PER_LAST;
                    if (sc_q != {CW{1'b1}}) begin
                        sc_d = sc_q + CW'(1);
                    end else begin
                        sc_d = sc_q;
                    end
                end else begin
                    state_d = RUN_IDLE;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = LOAD_IDLE;
            end
        endcase

        if (clear_i) begin
            state_d = LOAD_IDLE;
            cnt_d   = {PW_W{1'b0}};
            per_d   = PER_LAST;
            phase_d = 2'd0;
            last_d  = 1'b0;
            pend_d  = 1'b0;
            sc_d    = {CW{1'b0}};
            data_d  = {DW{1'b0}};
        end else begin
            phase_d = phase_d;
        end

        next_d   = (state_d == LOAD_HI) || (state_d == RUN_HI);
        done_d   = (state_d == DONE_HI);
        ready_d  = (state_d == LOAD_IDLE);
        busy_d   = (state_d == LOAD_HI) || (state_d == LOAD_LO) || (state_d == DONE_HI) ||
                   (state_d == DONE_LO) || (state_d == RUN_HI) || (state_d == RUN_LO);
        halted_d = (state_d == HALTED);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= LOAD_IDLE;
            cnt_q    <= {PW_W{1'b0}};
            per_q    <= PER_LAST;
            phase_q  <= 2'd0;
            last_q   <= 1'b0;
            pend_q   <= 1'b0;
            sc_q     <= {CW{1'b0}};
            data_q   <= {DW{1'b0}};
            next_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            phase_q  <= phase_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            sc_q     <= sc_d;
            data_q   <= data_d;
            next_q   <= next_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign cmd_ready_o  = ready_q;
    assign tm_data_o    = data_q;
    assign tm_next_o    = next_q;
    assign tm_done_o    = done_q;
    assign busy_o       = busy_q;
    assign halted_o     = halted_q;
    assign step_count_o = sc_q;

endmodule
